// File: rtl/packet_transfer_arbiter.sv
// Round-robin N-source packet-to-flit serializer feeding the NoC link.
// One source is granted per packet; completion/abort pulses free the source's buffer slot.
module packet_transfer_arbiter #(
  parameter  int N_SRC          = 2,
  parameter  int FLIT_W         = 64,
  parameter  int MAX_FLITS      = 8,
  parameter  int TIMEOUT_CYCLES = 256,
  localparam int IDX_W          = $clog2(MAX_FLITS + 1),
  localparam int SRC_W          = $clog2(N_SRC)
) (
  input  logic                              nocclk,
  input  logic                              rst,
  input  logic [N_SRC-1:0]                  src_valid,
  input  logic [N_SRC*MAX_FLITS*FLIT_W-1:0] src_buffer,
  input  logic [N_SRC*IDX_W-1:0]            src_tail_index,
  output logic [N_SRC-1:0]                  src_completed,
  output logic [N_SRC-1:0]                  src_aborted,
  input  logic                              flit_ready,
  output logic                              flit_valid,
  output logic [FLIT_W-1:0]                 flit,
  output logic [FLIT_W-1:0]                 head_flit,
  output logic [SRC_W-1:0]                  flit_src,
  output logic                              flit_last
);

  localparam int FI_W  = (MAX_FLITS > 1) ? $clog2(MAX_FLITS) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  localparam logic [IDX_W-1:0] TAIL_MAX  = IDX_W'(MAX_FLITS);
  localparam logic [SRC_W-1:0] LAST_SRC  = SRC_W'(N_SRC - 1);
  localparam logic [CNT_W-1:0] STALL_END = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [0:0]       state_q, state_d;
  logic [SRC_W-1:0] grant_q, grant_d;
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic [FLIT_W-1:0] flits_w [N_SRC][MAX_FLITS];
  logic [IDX_W-1:0]  tail_w  [N_SRC];

  for (genvar s = 0; s < N_SRC; s++) begin : g_src
    logic [IDX_W-1:0] tail_raw;
    assign tail_raw = src_tail_index[s*IDX_W +: IDX_W];
    assign tail_w[s] = (tail_raw > TAIL_MAX) ? TAIL_MAX : tail_raw;
    for (genvar i = 0; i < MAX_FLITS; i++) begin : g_flit
      assign flits_w[s][i] = src_buffer[(s*MAX_FLITS+i)*FLIT_W +: FLIT_W];
    end
  end

  // Round-robin search starting at rr_ptr, wrapping modulo N_SRC.
  logic             arb_found;
  logic [SRC_W-1:0] arb_pick;
  int               cand;

  always_comb begin
    // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latch).
    arb_found = 1'b0;
    arb_pick  = '0;
    cand      = 0;
    for (int k = 0; k < N_SRC; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= N_SRC) cand = cand - N_SRC;
      if (!arb_found && src_valid[cand]) begin
        arb_found = 1'b1;
        arb_pick  = SRC_W'(cand);
      end
    end
  end

  logic [IDX_W-1:0]  tail;
  logic              gnt_valid;
  logic [FLIT_W-1:0] cur_flit;
  logic [FLIT_W-1:0] cur_head;

  assign tail      = tail_w[grant_q];
  assign gnt_valid = src_valid[grant_q];
  assign cur_flit  = flits_w[grant_q][idx_q[FI_W-1:0]];
  assign cur_head  = flits_w[grant_q][0];

  logic              send_valid;
  logic              send_last;
  logic              handshake;
  logic              end_pkt;
  logic [N_SRC-1:0]  cmp_vec;
  logic [N_SRC-1:0]  abt_vec;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    idx_d      = idx_q;
    stall_d    = stall_q;
    send_valid = 1'b0;
    send_last  = 1'b0;
    handshake  = 1'b0;
    end_pkt    = 1'b0;
    cmp_vec    = '0;
    abt_vec    = '0;

    if (state_q == ST_IDLE) begin
      if (arb_found) begin
        state_d = ST_SEND;
        grant_d = arb_pick;
        idx_d   = '0;
        stall_d = '0;
      end
    end else begin
      send_valid = gnt_valid && (idx_q < tail);
      send_last  = send_valid && (idx_q == tail - IDX_W'(1));
      handshake  = send_valid && flit_ready;

      // Priority: lost valid, empty packet, handshake, then timeout.
      if (!gnt_valid) begin
        abt_vec[grant_q] = 1'b1;
        end_pkt          = 1'b1;
      end else if (tail == '0) begin
        cmp_vec[grant_q] = 1'b1;
        end_pkt          = 1'b1;
      end else if (handshake) begin
        if (send_last) begin
          cmp_vec[grant_q] = 1'b1;
          end_pkt          = 1'b1;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          stall_d = '0;
        end
      end else if ((TIMEOUT_CYCLES > 0) && (stall_q == STALL_END)) begin
        abt_vec[grant_q] = 1'b1;
        end_pkt          = 1'b1;
      end else begin
        stall_d = stall_q + CNT_W'(1);
      end

      if (end_pkt) begin
        state_d  = ST_IDLE;
        rr_ptr_d = (grant_q == LAST_SRC) ? '0 : grant_q + SRC_W'(1);
      end
    end
  end

  // Outputs are held at zero while reset is asserted so no pulse escapes a reset cycle.
  always_comb begin
    flit_valid    = 1'b0;
    flit          = '0;
    head_flit     = '0;
    flit_src      = '0;
    flit_last     = 1'b0;
    src_completed = '0;
    src_aborted   = '0;
    if (!rst && state_q == ST_SEND) begin
      flit_valid    = send_valid;
      flit_src      = grant_q;
      flit_last     = send_last;
      src_completed = cmp_vec;
      src_aborted   = abt_vec;
      if (send_valid) begin
        flit      = cur_flit;
        head_flit = cur_head;
      end
    end
  end

  always_ff @(posedge nocclk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      idx_q    <= '0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      idx_q    <= idx_d;
      stall_q  <= stall_d;
    end
  end

endmodule
